// File: rtl/uart_rx_ascii.sv
// 8N1 UART receiver feeding one ASCII character per frame to the parser.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err strobe.
module uart_rx_ascii #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] value,
  output logic       data_valid,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       frame_err
);

  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);

  localparam logic [CW-1:0] CNT_END  = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    value_q, value_d;
  logic          dv_q, dv_d;
  logic          fe_q, fe_d;
  logic          arm_q, arm_d;
  logic          par_q, par_d;
  logic          pe_q, pe_d;
  logic          par_ok;

  // a start edge counts only once the line has been seen high in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      value_q   <= '0;
      dv_q      <= 1'b0;
      fe_q      <= 1'b0;
      arm_q     <= 1'b0;
      par_q     <= 1'b0;
      pe_q      <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      value_q   <= value_d;
      dv_q      <= dv_d;
      fe_q      <= fe_d;
      arm_q     <= arm_d;
      par_q     <= par_d;
      pe_q      <= pe_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  assign par_ok = ~(^{shift_q, par_q});
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    value_d = value_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    arm_d   = arm_q;
    par_d   = par_q;
    pe_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_s_q) begin
          arm_d = 1'b1;
        end else if (arm_q) begin
          arm_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_END) begin
          cnt_d = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (cnt_q == CNT_END) begin
          cnt_d   = '0;
          par_d   = rx_s_q;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_END) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (!rx_s_q) begin
            fe_d = 1'b1;
          end else if (par_ok) begin
            value_d = shift_q;
            dv_d    = 1'b1;
          end else begin
            pe_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign value      = value_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = pe_q;
`endif

endmodule

// File: tb/tb_uart_rx_ascii.sv
// Scoreboard bench for uart_rx_ascii at 16 clocks per bit.
// Expected strobes are queued as frames are driven.
module tb_uart_rx_ascii;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  // edge -> stop mid (NB.5 bits) + 2 sync + 1 output reg
  localparam int LAT = NB * CPB + CPB / 2 + 3;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] value;
  logic       data_valid;
  logic       frame_err;
  logic       pe;

  uart_rx_ascii #(
    .CLK_FREQ(160),
    .BAUD    (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .value     (value),
    .data_valid(data_valid),
`ifdef UART_RX_PARITY_EN
    .parity_err(pe),
`endif
    .frame_err (frame_err)
  );

`ifndef UART_RX_PARITY_EN
  assign pe = 1'b0;
`endif

  typedef struct {
    int         k;
    logic [7:0] v;
    int         t;
  } ev_t;

  ev_t        sb[$];
  ev_t        e;
  int         n_tests;
  int         n_fail;
  int         cyc;
  int         got_k;
  logic [7:0] last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // k: 0 data_valid, 1 frame_err, 2 parity_err, -1 none
  task automatic send(input logic [7:0] b,
                      input logic       par,
                      input logic       stp,
                      input int         k);
    if (k >= 0) begin
      e.k = k;
      e.t = cyc + LAT;
      if (k == 0) last = b;
      e.v = last;
      sb.push_back(e);
    end
    rx = 1'b0;
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      hold(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    hold(CPB);
`endif
    rx = stp;
    hold(CPB);
    rx = 1'b1;
  endtask

  function automatic logic evp(input logic [7:0] b);
    return ^b;
  endfunction

  always @(negedge clk) begin
    if (rst && (data_valid || frame_err || pe)) begin
      got_k = data_valid ? 0 : (frame_err ? 1 : 2);
      chk("excl", {30'd0, data_valid, frame_err & data_valid}, 32'd0 | data_valid << 1);
      if (sb.size() == 0) begin
        chk("unexpected", got_k, 99);
      end else begin
        e = sb.pop_front();
        chk("kind", got_k, e.k);
        chk("value", value, e.v);
        chk("latency", cyc, e.t);
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    last    = 8'h00;
    rx      = 1'b1;
    rst     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_value", value, 8'h00);
    chk("rst_dv", data_valid, 1'b0);
    chk("rst_fe", frame_err, 1'b0);
    rst = 1'b1;
    hold(10);

    send(8'h35, evp(8'h35), 1'b1, 0);
    hold(20);

    send(8'h33, evp(8'h33), 1'b1, 0);
    send(8'h2B, evp(8'h2B), 1'b1, 0);
    send(8'h34, evp(8'h34), 1'b1, 0);
    hold(20);

    rx = 1'b0;
    hold(5);
    rx = 1'b1;
    hold(40);
    send(8'h2D, evp(8'h2D), 1'b1, 0);
    hold(20);

    send(8'h41, evp(8'h41), 1'b0, 1);
    hold(20);
    chk("fe_keep", value, 8'h2D);

    // break: line low for many bit times -> one frame_err only
    e.k = 1;
    e.v = last;
    e.t = cyc + LAT;
    sb.push_back(e);
    rx = 1'b0;
    hold(30 * CPB);
    rx = 1'b1;
    hold(30);
    chk("brk_drain", sb.size(), 0);
    send(8'h2A, evp(8'h2A), 1'b1, 0);
    hold(20);

    rx = 1'b0;
    hold(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(8'h37 >> i);
      hold(CPB);
    end
    rx = 1'b1;
    hold(6);
    rst = 1'b0;
    #1;
    chk("mid_value", value, 8'h00);
    chk("mid_dv", data_valid, 1'b0);
    chk("mid_fe", frame_err, 1'b0);
    last = 8'h00;
    hold(3);
    rst = 1'b1;
    hold(6 * CPB);
    send(8'h38, evp(8'h38), 1'b1, 0);
    hold(20);

`ifdef UART_RX_PARITY_EN
    send(8'h33, 1'b0, 1'b1, 0);
    hold(20);
    send(8'h33, 1'b1, 1'b1, 2);
    hold(20);
    chk("pe_keep", value, 8'h33);
    send(8'h35, 1'b1, 1'b0, 1);
    hold(20);
`endif

    for (int i = 0; i < 400 && sb.size() != 0; i++)
      hold(1);
    chk("drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
